fs_8to1_mux: RTL and testbench
==============================

# fs_8to1_mux

Single-bit full subtractor, a − b − bin, built from two 8:1 multiplexers whose data inputs are hard-wired truth-table constants. The 3-bit select is {a, b, bin}. The mux results pass through an output register stage with a valid flag. The block is a leaf arithmetic cell for ripple-borrow subtractor chains and for mux-based logic demonstrations.

## Interface
Parameters:
- REG_OUT, default 1: 1 = outputs registered (1-cycle latency); 0 = outputs driven combinationally from the muxes, and clk/rst affect only out_valid.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- a  input  1  minuend bit
- b  input  1  subtrahend bit
- bin  input  1  borrow-in
- in_valid  input  1  qualifies a/b/bin this cycle
- diff  output  1  difference bit, a ^ b ^ bin
- bout  output  1  borrow-out, (~a & b) | (~a & bin) | (b & bin)
- out_valid  output  1  diff/bout correspond to a valid input

One clock; reset is synchronous and active-high.

## Operation
- Select: sel[2:0] = {a, b, bin}; a is the MSB.
- Diff mux data D[7:0] = 8'h96. Per sel 0..7, diff is 0,1,1,0,1,0,0,1.
- Borrow mux data B[7:0] = 8'h8E. Per sel 0..7, bout is 0,1,1,1,0,0,0,1.
- Each mux output is data[sel]. The muxes contain no gates other than the selection itself.
- When REG_OUT=1, on each rising clk:
  - rst=1: diff, bout and out_valid are all cleared to 0.
  - in_valid=1: diff and bout load the mux outputs, and out_valid is set to 1.
  - in_valid=0: diff and bout hold their previous values, and out_valid is set to 0.
- When REG_OUT=0:
  - diff and bout are the mux outputs directly, and follow the inputs combinationally regardless of in_valid.
  - out_valid is a register: it takes in_valid on each clock edge and is cleared by rst.
- X/Z on any select bit gives an undefined result. The bench drives only known values.

## Timing
- REG_OUT=1: 1-cycle latency from input edge to output. Throughput is one result per cycle, and back-to-back valid inputs are allowed.
- REG_OUT=0: diff and bout have zero latency. out_valid lags in_valid by 1 cycle.
- Reset values: diff=0, bout=0, out_valid=0.
- rst has priority over in_valid in the same cycle.
- The first valid result appears on the edge after rst deasserts with in_valid=1.
- Reset asserted mid-stream drops the in-flight result. Outputs read 0 on the following cycle.

## Structure
- Shared package fs_pkg:
  - localparam FS_DIFF_TT = 8'h96
  - localparam FS_BOUT_TT = 8'h8E
  - typedef logic [2:0] fs_sel_t
- Sub-module mux_8to1: data[7:0], sel[2:0], y. Purely combinational, written as an explicit 8-way case.
- The top level instantiates mux_8to1 twice (diff, bout) and adds the REG_OUT generate branch for the output register.

## Test plan
- Exhaustive sweep, REG_OUT=1: after reset, drive {a,b,bin} = 0..7 with in_valid=1 on consecutive cycles.
  - One cycle later, diff must read 0,1,1,0,1,0,0,1.
  - bout must read 0,1,1,1,0,0,0,1.
  - out_valid must be 1 throughout.
- Reset: hold rst=1 for 2 cycles with {a,b,bin}=3'd7 and in_valid=1.
  - Outputs must be diff=0, bout=0, out_valid=0.
  - First edge after release: diff=1, bout=1.
- Hold behaviour: apply sel=3'd1 valid, then sel=3'd4 with in_valid=0.
  - diff=1 and bout=1 must be held.
  - out_valid must drop to 0.
- Mid-stream reset: stream sel 2,3,5, asserting rst on the cycle sel=3 is presented.
  - Outputs must be 0 for that cycle.
  - The next valid input, sel=5, must give diff=0, bout=0.
- REG_OUT=0: step {a,b,bin} through 0..7 every 10 time units without a clock edge.
  - diff/bout must match the truth table within the same step.
  - out_valid must stay 0 until the first clk edge with in_valid=1.
- Reference-model check: apply 200 random valid inputs.
  - Each output must equal {bout,diff} = {a,b,bin} mapped through the 2-bit result of a − b − bin.

Source files
------------

// File: rtl/fs_pkg.sv
// Shared constants and types for the mux-based full subtractor cell.
package fs_pkg;

  // Truth tables indexed by sel = {a, b, bin}; bit n is the result for sel == n.
  localparam logic [7:0] FS_DIFF_TT = 8'h96;
  localparam logic [7:0] FS_BOUT_TT = 8'h8E;

  typedef logic [2:0] fs_sel_t;

endpackage

// File: rtl/mux_8to1.sv
// Plain 8:1 multiplexer: y = data[sel], written as an explicit case.
module mux_8to1
  import fs_pkg::*;
(
  input  logic [7:0] data,
  input  fs_sel_t    sel,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    case (sel)
      3'd0: y = data[0];
      3'd1: y = data[1];
      3'd2: y = data[2];
      3'd3: y = data[3];
      3'd4: y = data[4];
      3'd5: y = data[5];
      3'd6: y = data[6];
      3'd7: y = data[7];
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/fs_8to1_mux.sv
// Single-bit full subtractor (a - b - bin) built from two hard-wired 8:1 muxes,
// with an optional output register stage and a valid flag.
module fs_8to1_mux
  import fs_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic bin,
  input  logic in_valid,
  output logic diff,
  output logic bout,
  output logic out_valid
);

  // Valid semantics: in_valid qualifies a/b/bin in the cycle it is high; there is
  // no backpressure. out_valid marks that diff/bout reflect an input accepted on
  // the previous edge (REG_OUT=1) or that in_valid was high last edge (REG_OUT=0).

  fs_sel_t sel;
  logic    diff_mux;
  logic    bout_mux;

  assign sel = {a, b, bin};

  mux_8to1 u_diff_mux (
    .data (FS_DIFF_TT),
    .sel  (sel),
    .y    (diff_mux)
  );

  mux_8to1 u_bout_mux (
    .data (FS_BOUT_TT),
    .sel  (sel),
    .y    (bout_mux)
  );

  generate
    if (REG_OUT) begin : g_reg
      // Results hold while in_valid is low; only out_valid tracks the gap.
      always_ff @(posedge clk) begin
        if (rst) begin
          diff      <= 1'b0;
          bout      <= 1'b0;
          out_valid <= 1'b0;
        end else begin
          out_valid <= in_valid;
          if (in_valid) begin
            diff <= diff_mux;
            bout <= bout_mux;
          end
        end
      end
    end else begin : g_comb
      assign diff = diff_mux;
      assign bout = bout_mux;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
        end else begin
          out_valid <= in_valid;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fs_8to1_mux.sv
// Self-checking bench for fs_8to1_mux: registered instance via a scoreboard,
// combinational instance via direct steps with its clock held.
module tb_fs_8to1_mux;

  // Clock and reset
  logic clk = 1'b0;
  logic clk0 = 1'b0;
  logic clk0_run = 1'b0;

  always #5 clk = ~clk;
  always #5 clk0 = clk0_run ? ~clk0 : 1'b0;

  // Registered instance signals
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, bin = 1'b0, in_valid = 1'b0;
  logic diff, bout, out_valid;

  // Combinational instance signals
  logic rst0 = 1'b1;
  logic a0 = 1'b0, b0 = 1'b0, bin0 = 1'b0, in_valid0 = 1'b0;
  logic diff0, bout0, out_valid0;

  fs_8to1_mux #(.REG_OUT(1'b1)) dut_reg (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .in_valid  (in_valid),
    .diff      (diff),
    .bout      (bout),
    .out_valid (out_valid)
  );

  fs_8to1_mux #(.REG_OUT(1'b0)) dut_comb (
    .clk       (clk0),
    .rst       (rst0),
    .a         (a0),
    .b         (b0),
    .bin       (bin0),
    .in_valid  (in_valid0),
    .diff      (diff0),
    .bout      (bout0),
    .out_valid (out_valid0)
  );

  // Scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] exp_q[$];
  logic m_diff = 1'b0, m_bout = 1'b0, m_valid = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: 2-bit two's complement result of a - b - bin; bit1 is the borrow.
  function automatic logic [1:0] ref_sub(input logic [2:0] s);
    logic [1:0] r;
    r = {1'b0, s[2]} - {1'b0, s[1]} - {1'b0, s[0]};
    return r;
  endfunction

  // Driver: present one cycle of stimulus, update the model, compare after the edge.
  task automatic drive_cycle(input string tag, input logic r, input logic [2:0] s, input logic v);
    logic [1:0] res;
    logic [2:0] got;
    rst = r;
    {a, b, bin} = s;
    in_valid = v;
    res = ref_sub(s);
    if (r) begin
      m_diff = 1'b0; m_bout = 1'b0; m_valid = 1'b0;
    end else begin
      m_valid = v;
      if (v) begin
        m_diff = res[0];
        m_bout = res[1];
      end
    end
    exp_q.push_back({m_valid, m_bout, m_diff});
    @(posedge clk);
    #1;
    got = {out_valid, bout, diff};
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 8'd0, 8'd1);
    end else begin
      check(tag, {5'd0, got}, {5'd0, exp_q.pop_front()});
    end
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    drive_cycle("reset_init", 1'b1, 3'd0, 1'b0);

    // Exhaustive sweep, back-to-back valid
    for (int i = 0; i < 8; i++) drive_cycle("sweep", 1'b0, 3'(i), 1'b1);

    // Reset held 2 cycles with sel=7 valid, then release
    drive_cycle("rst_hold", 1'b1, 3'd7, 1'b1);
    drive_cycle("rst_hold", 1'b1, 3'd7, 1'b1);
    drive_cycle("rst_release", 1'b0, 3'd7, 1'b1);
    check("rst_release_diff", {7'd0, diff}, 8'd1);
    check("rst_release_bout", {7'd0, bout}, 8'd1);

    // Hold behaviour
    drive_cycle("hold_load", 1'b0, 3'd1, 1'b1);
    drive_cycle("hold_idle", 1'b0, 3'd4, 1'b0);
    drive_cycle("hold_idle2", 1'b0, 3'd6, 1'b0);

    // Mid-stream reset drops the in-flight result
    drive_cycle("mid_s2", 1'b0, 3'd2, 1'b1);
    drive_cycle("mid_rst", 1'b1, 3'd3, 1'b1);
    drive_cycle("mid_s5", 1'b0, 3'd5, 1'b1);

    // Random valid inputs against the arithmetic model
    for (int i = 0; i < 200; i++) drive_cycle("random", 1'b0, 3'($urandom_range(0, 7)), 1'b1);
    drive_cycle("drain_idle", 1'b0, 3'd0, 1'b0);

    // Combinational instance: reset with its clock running, then stop the clock
    clk0_run = 1'b1;
    rst0 = 1'b1;
    in_valid0 = 1'b0;
    repeat (2) @(posedge clk0);
    #1 rst0 = 1'b0;
    @(posedge clk0);
    #1 clk0_run = 1'b0;
    #20;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] res;
      {a0, b0, bin0} = 3'(i);
      in_valid0 = (i >= 4);
      res = ref_sub(3'(i));
      #1;
      check("comb_diff", {7'd0, diff0}, {7'd0, res[0]});
      check("comb_bout", {7'd0, bout0}, {7'd0, res[1]});
      check("comb_valid_idle", {7'd0, out_valid0}, 8'd0);
      #9;
    end
    in_valid0 = 1'b1;
    clk0_run = 1'b1;
    @(posedge clk0);
    #1 check("comb_valid_edge", {7'd0, out_valid0}, 8'd1);
    in_valid0 = 1'b0;
    @(posedge clk0);
    #1 check("comb_valid_lag", {7'd0, out_valid0}, 8'd0);
    clk0_run = 1'b0;

    check("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
